// File: rtl/lab1_debounce_pkg.sv
// Shared types and helpers for the lab1 push-button debouncer.
// Consumed by lab1_debounce_channel and lab1_button_debouncer.
package lab1_debounce_pkg;

   typedef enum logic [1:0] {
      IDLE_REL   = 2'd0,
      CAND_PRESS = 2'd1,
      HELD       = 2'd2,
      CAND_REL   = 2'd3
   } db_state_t;

   localparam int DEFAULT_STABLE_CYCLES = 1_000_000;

   // Counter must be able to hold STABLE_CYCLES itself, hence the +1.
   function automatic int cnt_width(input int stable);
      return $clog2(stable + 1);
   endfunction

endpackage

// File: rtl/lab1_debounce_channel.sv
// One debouncer channel: two-flop synchroniser, stability counter and FSM.
// Press/release strobe registers exist only when DEBOUNCE_PULSE_EN is defined.
module lab1_debounce_channel
   import lab1_debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic button_raw,
   output logic button_db,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int               CNT_W   = cnt_width(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] count;
   db_state_t        state;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= button_raw ^ ACTIVE_LOW;
         sync2 <= sync1;
      end
   end

`ifdef DEBOUNCE_PULSE_EN
   logic press_q;
   logic release_q;
`endif

   // A candidate state is only left towards the new level once the counter
   // has reached STABLE_CYCLES and the sample still agrees; any disagreeing
   // sample drops straight back to the settled state with the count cleared.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE_REL;
         count     <= '0;
         button_db <= 1'b0;
`ifdef DEBOUNCE_PULSE_EN
         press_q   <= 1'b0;
         release_q <= 1'b0;
`endif
      end else begin
`ifdef DEBOUNCE_PULSE_EN
         press_q   <= 1'b0;
         release_q <= 1'b0;
`endif
         case (state)
            IDLE_REL: begin
               if (sync2) begin
                  state <= CAND_PRESS;
                  count <= CNT_ONE;
               end else begin
                  count <= '0;
               end
            end
            CAND_PRESS: begin
               if (!sync2) begin
                  state <= IDLE_REL;
                  count <= '0;
               end else if (count == CNT_MAX) begin
                  state     <= HELD;
                  button_db <= 1'b1;
                  count     <= '0;
`ifdef DEBOUNCE_PULSE_EN
                  press_q   <= 1'b1;
`endif
               end else begin
                  count <= count + CNT_ONE;
               end
            end
            HELD: begin
               if (!sync2) begin
                  state <= CAND_REL;
                  count <= CNT_ONE;
               end else begin
                  count <= '0;
               end
            end
            CAND_REL: begin
               if (sync2) begin
                  state <= HELD;
                  count <= '0;
               end else if (count == CNT_MAX) begin
                  state     <= IDLE_REL;
                  button_db <= 1'b0;
                  count     <= '0;
`ifdef DEBOUNCE_PULSE_EN
                  release_q <= 1'b1;
`endif
               end else begin
                  count <= count + CNT_ONE;
               end
            end
            default: begin
               state     <= IDLE_REL;
               count     <= '0;
               button_db <= 1'b0;
            end
         endcase
      end
   end

`ifdef DEBOUNCE_PULSE_EN
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
`else
   assign press_pulse   = 1'b0;
   assign release_pulse = 1'b0;
`endif

endmodule

// File: rtl/lab1_button_debouncer.sv
// WIDTH-channel button debouncer feeding the button PIO in_port.
// Strobe outputs are live only when DEBOUNCE_PULSE_EN is defined, else tied to 0.
module lab1_button_debouncer
   import lab1_debounce_pkg::*;
#(
   parameter int WIDTH         = 5,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] buttons_raw,
   output logic [WIDTH-1:0] buttons_db,
   output logic [WIDTH-1:0] press_pulse,
   output logic [WIDTH-1:0] release_pulse
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      lab1_debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .ACTIVE_LOW    (ACTIVE_LOW)
      ) u_chan (
         .clk           (clk),
         .reset         (reset),
         .button_raw    (buttons_raw[i]),
         .button_db     (buttons_db[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i])
      );
   end

endmodule

// File: tb/tb_lab1_button_debouncer.sv
// Self-checking bench for lab1_button_debouncer: directed scenarios plus random
// stimulus against a run-length reference model. Honours DEBOUNCE_PULSE_EN.
module tb_lab1_button_debouncer;

   localparam int WIDTH         = 5;
   localparam int STABLE_CYCLES = 4;
   localparam bit ACTIVE_LOW    = 1'b1;
`ifdef DEBOUNCE_PULSE_EN
   localparam logic [WIDTH-1:0] PULSE_MASK = {WIDTH{1'b1}};
`else
   localparam logic [WIDTH-1:0] PULSE_MASK = '0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] buttons_raw;
   logic [WIDTH-1:0] buttons_db;
   logic [WIDTH-1:0] press_pulse;
   logic [WIDTH-1:0] release_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a two-sample delay line, then a new level is accepted
   // once STABLE_CYCLES+1 consecutive delayed samples differ from the current level.
   logic [WIDTH-1:0] m_d1, m_d2, m_db, m_press, m_rel;
   int               m_run [WIDTH];

   lab1_button_debouncer #(
      .WIDTH         (WIDTH),
      .STABLE_CYCLES (STABLE_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .buttons_raw   (buttons_raw),
      .buttons_db    (buttons_db),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse)
   );

   always #5 clk = ~clk;

   task automatic advance();
      logic [WIDTH-1:0] seen;
      if (reset) begin
         m_d1 = '0; m_d2 = '0; m_db = '0; m_press = '0; m_rel = '0;
         for (int ch = 0; ch < WIDTH; ch++) m_run[ch] = 0;
      end else begin
         seen = m_d2;
         m_press = '0;
         m_rel   = '0;
         for (int ch = 0; ch < WIDTH; ch++) begin
            if (seen[ch] != m_db[ch]) begin
               m_run[ch]++;
               if (m_run[ch] == STABLE_CYCLES + 1) begin
                  m_db[ch] = seen[ch];
                  if (seen[ch]) m_press[ch] = 1'b1;
                  else          m_rel[ch]   = 1'b1;
                  m_run[ch] = 0;
               end
            end else begin
               m_run[ch] = 0;
            end
         end
         m_d2 = m_d1;
         m_d1 = buttons_raw ^ {WIDTH{ACTIVE_LOW}};
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      buttons_raw = 5'h1F;
      for (int i = 0; i < 23; i++) begin
         if (i == 3) reset = 1'b0;
         advance();
         n_checks += 3;
         if (buttons_db !== 5'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_db cycle %0d: got %h expected 00", i, buttons_db);
         end
         if (press_pulse !== 5'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_press cycle %0d: got %h expected 00", i, press_pulse);
         end
         if (release_pulse !== 5'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_release cycle %0d: got %h expected 00", i, release_pulse);
         end
      end
   endtask

   task automatic test_clean_press();
      logic [WIDTH-1:0] exp_db, exp_p;
      buttons_raw[2] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         advance();
         exp_db = (i >= 6) ? 5'h04 : 5'h00;
         exp_p  = (i == 6) ? (5'h04 & PULSE_MASK) : 5'h00;
         n_checks += 4;
         if (buttons_db !== exp_db) begin
            n_fail++;
            $display("[TB] FAIL press_db cycle %0d: got %h expected %h", i, buttons_db, exp_db);
         end
         if (press_pulse !== exp_p) begin
            n_fail++;
            $display("[TB] FAIL press_pulse cycle %0d: got %h expected %h", i, press_pulse, exp_p);
         end
         if (release_pulse !== 5'h00) begin
            n_fail++;
            $display("[TB] FAIL press_release cycle %0d: got %h expected 00", i, release_pulse);
         end
         if (buttons_db !== m_db) begin
            n_fail++;
            $display("[TB] FAIL press_model cycle %0d: got %h expected %h", i, buttons_db, m_db);
         end
      end
   endtask

   task automatic test_bounce();
      logic [WIDTH-1:0] exp_db, exp_p;
      for (int i = 0; i < 8; i++) begin
         buttons_raw[0] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
         advance();
         n_checks += 2;
         if (buttons_db !== 5'h04) begin
            n_fail++;
            $display("[TB] FAIL bounce_db cycle %0d: got %h expected 04", i, buttons_db);
         end
         if (press_pulse !== 5'h00) begin
            n_fail++;
            $display("[TB] FAIL bounce_press cycle %0d: got %h expected 00", i, press_pulse);
         end
      end
      buttons_raw[0] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         advance();
         exp_db = (i >= 6) ? 5'h05 : 5'h04;
         exp_p  = (i == 6) ? (5'h01 & PULSE_MASK) : 5'h00;
         n_checks += 2;
         if (buttons_db !== exp_db) begin
            n_fail++;
            $display("[TB] FAIL bounce_settle_db cycle %0d: got %h expected %h", i, buttons_db, exp_db);
         end
         if (press_pulse !== exp_p) begin
            n_fail++;
            $display("[TB] FAIL bounce_settle_press cycle %0d: got %h expected %h", i, press_pulse, exp_p);
         end
      end
   endtask

   task automatic test_release();
      logic [WIDTH-1:0] exp_db, exp_r;
      for (int i = 0; i < 14; i++) begin
         buttons_raw[2] = (i < 3) ? 1'b1 : 1'b0;
         advance();
         n_checks += 2;
         if (buttons_db !== 5'h05) begin
            n_fail++;
            $display("[TB] FAIL glitch_db cycle %0d: got %h expected 05", i, buttons_db);
         end
         if (release_pulse !== 5'h00) begin
            n_fail++;
            $display("[TB] FAIL glitch_release cycle %0d: got %h expected 00", i, release_pulse);
         end
      end
      buttons_raw[2] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         advance();
         exp_db = (i >= 6) ? 5'h01 : 5'h05;
         exp_r  = (i == 6) ? (5'h04 & PULSE_MASK) : 5'h00;
         n_checks += 2;
         if (buttons_db !== exp_db) begin
            n_fail++;
            $display("[TB] FAIL release_db cycle %0d: got %h expected %h", i, buttons_db, exp_db);
         end
         if (release_pulse !== exp_r) begin
            n_fail++;
            $display("[TB] FAIL release_pulse cycle %0d: got %h expected %h", i, release_pulse, exp_r);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [WIDTH-1:0] exp_db, exp_p;
      buttons_raw = 5'h1F;
      repeat (12) advance();
      buttons_raw = 5'h0D;
      for (int i = 0; i < 10; i++) begin
         advance();
         exp_db = (i >= 6) ? 5'h12 : 5'h00;
         exp_p  = (i == 6) ? (5'h12 & PULSE_MASK) : 5'h00;
         n_checks += 2;
         if (buttons_db !== exp_db) begin
            n_fail++;
            $display("[TB] FAIL simul_db cycle %0d: got %h expected %h", i, buttons_db, exp_db);
         end
         if (press_pulse !== exp_p) begin
            n_fail++;
            $display("[TB] FAIL simul_press cycle %0d: got %h expected %h", i, press_pulse, exp_p);
         end
      end
      buttons_raw = 5'h1F;
      repeat (12) advance();
   endtask

   task automatic test_reset_mid_count();
      logic [WIDTH-1:0] exp_db, exp_p;
      buttons_raw = 5'h17;
      repeat (4) advance();
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         advance();
         n_checks += 2;
         if (buttons_db !== 5'h00) begin
            n_fail++;
            $display("[TB] FAIL midreset_db cycle %0d: got %h expected 00", i, buttons_db);
         end
         if (press_pulse !== 5'h00) begin
            n_fail++;
            $display("[TB] FAIL midreset_press cycle %0d: got %h expected 00", i, press_pulse);
         end
      end
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         advance();
         exp_db = (i >= 6) ? 5'h08 : 5'h00;
         exp_p  = (i == 6) ? (5'h08 & PULSE_MASK) : 5'h00;
         n_checks += 2;
         if (buttons_db !== exp_db) begin
            n_fail++;
            $display("[TB] FAIL rearm_db cycle %0d: got %h expected %h", i, buttons_db, exp_db);
         end
         if (press_pulse !== exp_p) begin
            n_fail++;
            $display("[TB] FAIL rearm_press cycle %0d: got %h expected %h", i, press_pulse, exp_p);
         end
      end
   endtask

   task automatic test_random();
      int hold;
      int cyc = 0;
      for (int seg = 0; seg < 80; seg++) begin
         reset = ($urandom_range(0, 19) == 0);
         buttons_raw = WIDTH'($urandom);
         hold = reset ? $urandom_range(1, 2) : $urandom_range(1, 9);
         for (int k = 0; k < hold; k++) begin
            advance();
            cyc++;
            n_checks += 4;
            if (buttons_db !== m_db) begin
               n_fail++;
               $display("[TB] FAIL rand_db cycle %0d: got %h expected %h", cyc, buttons_db, m_db);
            end
            if (press_pulse !== (m_press & PULSE_MASK)) begin
               n_fail++;
               $display("[TB] FAIL rand_press cycle %0d: got %h expected %h", cyc, press_pulse, m_press & PULSE_MASK);
            end
            if (release_pulse !== (m_rel & PULSE_MASK)) begin
               n_fail++;
               $display("[TB] FAIL rand_release cycle %0d: got %h expected %h", cyc, release_pulse, m_rel & PULSE_MASK);
            end
            if ((press_pulse & release_pulse) !== 5'h00) begin
               n_fail++;
               $display("[TB] FAIL rand_overlap cycle %0d: got %h expected 00", cyc, press_pulse & release_pulse);
            end
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      buttons_raw = 5'h1F;
      m_d1 = '0; m_d2 = '0; m_db = '0; m_press = '0; m_rel = '0;
      for (int ch = 0; ch < WIDTH; ch++) m_run[ch] = 0;
      @(negedge clk);
      test_reset();
      test_clean_press();
      test_bounce();
      test_release();
      test_simultaneous();
      test_reset_mid_count();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
